// File: rtl/smvm_pkg.sv
// Shared types and width helpers for the sparse matrix-vector stream engine.
package smvm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VEC_LOAD = 2'd1,
    MAT      = 2'd2,
    DRAIN    = 2'd3
  } smvm_state_e;

  function automatic int col_width(input int max_cols);
    return (max_cols > 1) ? $clog2(max_cols) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A row sum of up to 2^col_w full-scale products must fit without wrapping.
  function automatic bit acc_w_ok(input int val_w, input int col_w, input int acc_w);
    return acc_w >= (2 * val_w + col_w);
  endfunction

endpackage

// File: rtl/smvm_if.sv
// Vector, matrix-packet and result channels of the stream engine.
interface smvm_if #(
  parameter int K     = 4,
  parameter int VAL_W = 8,
  parameter int COL_W = 8,
  parameter int ACC_W = 24
);
  logic                 vec_valid;
  logic                 vec_ready;
  logic [VAL_W-1:0]     vec_data;

  logic                 mat_valid;
  logic                 mat_ready;
  logic [K-1:0]         mat_en;
  logic [K*VAL_W-1:0]   mat_val;
  logic [K*COL_W-1:0]   mat_col;
  logic [K-1:0]         mat_rend;
  logic                 mat_last;

  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_data;

  modport master (
    output vec_valid, vec_data,
    output mat_valid, mat_en, mat_val, mat_col, mat_rend, mat_last,
    output out_ready,
    input  vec_ready, mat_ready, out_valid, out_data
  );

  modport slave (
    input  vec_valid, vec_data,
    input  mat_valid, mat_en, mat_val, mat_col, mat_rend, mat_last,
    input  out_ready,
    output vec_ready, mat_ready, out_valid, out_data
  );
endinterface

// File: rtl/smvm_seg_reducer.sv
// Combinational K-lane segmented scan: each enabled row-end lane closes a row,
// the tail after the last row end (or the whole packet) rolls into the carry.
module smvm_seg_reducer
  import smvm_pkg::*;
#(
  parameter int K     = 4,
  parameter int VAL_W = 8,
  parameter int ACC_W = 24,
  parameter int EC_W  = $clog2(K + 1)
) (
  input  logic [ACC_W-1:0]            carry_in,
  input  logic                        open_in,
  input  logic [K-1:0][2*VAL_W-1:0]   p,
  input  logic [K-1:0]                en,
  input  logic [K-1:0]                rend,
  output logic [K-1:0][ACC_W-1:0]     sums,
  output logic [K-1:0]                emit,
  output logic [EC_W-1:0]             emit_cnt,
  output logic [ACC_W-1:0]            carry_out,
  output logic                        open_out
);

  logic [ACC_W-1:0] run_s;
  logic             open_s;

  // Left-to-right scan; open_s tracks whether a row has started but not ended.
  always_comb begin
    run_s    = carry_in;
    open_s   = open_in;
    sums     = '0;
    emit     = '0;
    emit_cnt = '0;
    for (int i = 0; i < K; i++) begin
      if (en[i]) begin
        run_s  = run_s + ACC_W'(p[i]);
        open_s = 1'b1;
      end else begin
        run_s  = run_s;
      end
      sums[i] = run_s;
      if (en[i] && rend[i]) begin
        emit[i]  = 1'b1;
        emit_cnt = emit_cnt + EC_W'(1);
        run_s    = '0;
        open_s   = 1'b0;
      end else begin
        emit[i]  = 1'b0;
      end
    end
    carry_out = run_s;
    open_out  = open_s;
  end

endmodule

// File: rtl/smvm_stream_engine.sv
// Sparse matrix-vector multiply engine: vector RAM load, K-lane product stage,
// segmented reduction with cross-packet carry, and a multi-push result FIFO.
module smvm_stream_engine
  import smvm_pkg::*;
#(
  parameter int K         = 4,
  parameter int VAL_W     = 8,
  parameter int MAX_COLS  = 256,
  parameter int ACC_W     = 24,
  parameter int OUT_DEPTH = 16,
  localparam int COL_W    = col_width(MAX_COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [COL_W:0]  cfg_cols,
  smvm_if.slave           bus,
  output logic            done,
  output logic            err
);

  localparam int CNT_W = cnt_width(OUT_DEPTH);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int EC_W  = $clog2(K + 1);
  localparam int P_W   = 2 * VAL_W;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(OUT_DEPTH);
  localparam logic [CNT_W-1:0] RESERVE_C = CNT_W'(3 * K);

  if (!acc_w_ok(VAL_W, COL_W, ACC_W)) begin : g_acc_w_check
    $error("smvm_stream_engine: ACC_W too narrow for VAL_W/MAX_COLS");
  end

  smvm_state_e state_r, state_next_s;

  logic [COL_W:0]    cols_r;
  logic [COL_W-1:0]  vidx_r;
  logic [VAL_W-1:0]  x_mem [MAX_COLS];

  logic vec_ready_r, mat_ready_r, out_valid_r, done_r, err_r;
  logic vec_fire_s, mat_fire_s, pop_s, last_vec_s, drained_s, oob_s;

  logic                        s0_valid_r, s0_last_r;
  logic [K-1:0]                s0_en_r, s0_rend_r;
  logic [K-1:0][VAL_W-1:0]     s0_val_r;
  logic [K-1:0][COL_W-1:0]     s0_col_r;
  logic [K-1:0]                s0_inrange_s;
  logic [K-1:0][P_W-1:0]       s0_p_s;

  logic                        s1_valid_r, s1_last_r;
  logic [K-1:0]                s1_en_r, s1_rend_r;
  logic [K-1:0][P_W-1:0]       s1_p_r;

  logic [ACC_W-1:0]            carry_r;
  logic                        open_r;
  logic [K-1:0][ACC_W-1:0]     sums_s;
  logic [K-1:0]                emit_s;
  logic [EC_W-1:0]             emit_cnt_s;
  logic [ACC_W-1:0]            carry_out_s;
  logic                        open_out_s;
  logic                        extra_s;
  logic [EC_W-1:0]             push_n_s;

  logic [ACC_W-1:0]            fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]            count_r, count_next_s;
  logic [K-1:0][PTR_W-1:0]     lane_wr_s;
  logic [PTR_W-1:0]            extra_wr_s;
  logic [EC_W-1:0]             off_s;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base,
                                               input logic [EC_W-1:0]  off);
    int sum;
    sum = int'(base) + int'(off);
    if (sum >= OUT_DEPTH) begin
      sum = sum - OUT_DEPTH;
    end else begin
      sum = sum;
    end
    return PTR_W'(sum);
  endfunction

  assign vec_fire_s = bus.vec_valid & vec_ready_r;
  assign mat_fire_s = bus.mat_valid & mat_ready_r;
  assign pop_s      = out_valid_r & bus.out_ready;
  assign last_vec_s = ({1'b0, vidx_r} == (cols_r - (COL_W + 1)'(1)));
  assign drained_s  = !s0_valid_r && !s1_valid_r && (count_r == '0);

  assign bus.vec_ready = vec_ready_r;
  assign bus.mat_ready = mat_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = fifo_mem[rd_ptr_r];
  assign done          = done_r;
  assign err           = err_r;

  // Job sequencing: load vector, stream matrix, drain pipeline and FIFO.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = VEC_LOAD;
        else       state_next_s = IDLE;
      end
      VEC_LOAD: begin
        if (vec_fire_s && last_vec_s) state_next_s = MAT;
        else                          state_next_s = VEC_LOAD;
      end
      MAT: begin
        if (mat_fire_s && bus.mat_last) state_next_s = DRAIN;
        else                            state_next_s = MAT;
      end
      DRAIN: begin
        if (drained_s) state_next_s = IDLE;
        else           state_next_s = DRAIN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Product lanes: out-of-range or disabled lanes contribute zero.
  always_comb begin
    s0_inrange_s = '0;
    s0_p_s       = '0;
    for (int i = 0; i < K; i++) begin
      s0_inrange_s[i] = ({1'b0, s0_col_r[i]} < cols_r);
      if (s0_en_r[i] && s0_inrange_s[i]) begin
        s0_p_s[i] = P_W'(s0_val_r[i]) * P_W'(x_mem[s0_col_r[i]]);
      end else begin
        s0_p_s[i] = '0;
      end
    end
  end

  assign oob_s = s0_valid_r && ((s0_en_r & ~s0_inrange_s) != '0);

  smvm_seg_reducer #(
    .K     (K),
    .VAL_W (VAL_W),
    .ACC_W (ACC_W),
    .EC_W  (EC_W)
  ) u_reducer (
    .carry_in  (carry_r),
    .open_in   (open_r),
    .p         (s1_p_r),
    .en        (s1_en_r),
    .rend      (s1_rend_r),
    .sums      (sums_s),
    .emit      (emit_s),
    .emit_cnt  (emit_cnt_s),
    .carry_out (carry_out_s),
    .open_out  (open_out_s)
  );

  // A dangling row at the final packet is flushed as one extra result.
  assign extra_s  = s1_valid_r && s1_last_r && (open_out_s || (carry_out_s != '0));
  assign push_n_s = s1_valid_r ? (emit_cnt_s + EC_W'(extra_s)) : '0;
  assign count_next_s = count_r + CNT_W'(push_n_s) - CNT_W'(pop_s);

  // Compact emitted lanes into consecutive FIFO slots in lane order.
  always_comb begin
    off_s     = '0;
    lane_wr_s = '0;
    for (int i = 0; i < K; i++) begin
      lane_wr_s[i] = ptr_add(wr_ptr_r, off_s);
      if (emit_s[i]) off_s = off_s + EC_W'(1);
      else           off_s = off_s;
    end
    extra_wr_s = ptr_add(wr_ptr_r, emit_cnt_s);
  end

  // Vector RAM write port.
  always_ff @(posedge clk) begin
    if (vec_fire_s) begin
      x_mem[vidx_r] <= bus.vec_data;
    end
  end

  // Result FIFO storage; occupancy and pointers live in the reset domain below.
  always_ff @(posedge clk) begin
    if (s1_valid_r) begin
      for (int i = 0; i < K; i++) begin
        if (emit_s[i]) fifo_mem[lane_wr_s[i]] <= sums_s[i];
      end
      if (extra_s) fifo_mem[extra_wr_s] <= carry_out_s;
    end
  end

  // Control, pipeline registers, carry and FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cols_r      <= '0;
      vidx_r      <= '0;
      s0_valid_r  <= 1'b0;
      s0_last_r   <= 1'b0;
      s0_en_r     <= '0;
      s0_rend_r   <= '0;
      s0_val_r    <= '0;
      s0_col_r    <= '0;
      s1_valid_r  <= 1'b0;
      s1_last_r   <= 1'b0;
      s1_en_r     <= '0;
      s1_rend_r   <= '0;
      s1_p_r      <= '0;
      carry_r     <= '0;
      open_r      <= 1'b0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      vec_ready_r <= 1'b0;
      mat_ready_r <= 1'b0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_r == IDLE && start) cols_r <= cfg_cols;
      if (vec_fire_s) vidx_r <= last_vec_s ? '0 : (vidx_r + COL_W'(1));

      s0_valid_r <= mat_fire_s;
      if (mat_fire_s) begin
        s0_last_r <= bus.mat_last;
        s0_en_r   <= bus.mat_en;
        s0_rend_r <= bus.mat_rend;
        s0_val_r  <= bus.mat_val;
        s0_col_r  <= bus.mat_col;
      end

      s1_valid_r <= s0_valid_r;
      if (s0_valid_r) begin
        s1_last_r <= s0_last_r;
        s1_en_r   <= s0_en_r;
        s1_rend_r <= s0_rend_r & s0_en_r;
        s1_p_r    <= s0_p_s;
      end

      if (s1_valid_r) begin
        carry_r <= s1_last_r ? '0 : carry_out_s;
        open_r  <= s1_last_r ? 1'b0 : open_out_s;
      end

      wr_ptr_r <= ptr_add(wr_ptr_r, push_n_s);
      if (pop_s) rd_ptr_r <= ptr_add(rd_ptr_r, EC_W'(1));
      count_r  <= count_next_s;

      // Space for the current packet plus two still in the pipeline.
      vec_ready_r <= (state_next_s == VEC_LOAD);
      mat_ready_r <= (state_next_s == MAT) && ((DEPTH_C - count_next_s) >= RESERVE_C);
      out_valid_r <= (count_next_s != '0);
      done_r      <= (state_r == DRAIN) && drained_s;

      if (state_r == IDLE && start) err_r <= 1'b0;
      else if (oob_s || extra_s)    err_r <= 1'b1;
      else                          err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_smvm_stream_engine.sv
// Directed self-checking bench for smvm_stream_engine (K=4, 8-bit values).
module tb_smvm_stream_engine;

  localparam int K = 4, VAL_W = 8, MAX_COLS = 256, ACC_W = 24, OUT_DEPTH = 16, COL_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [COL_W:0] cfg_cols = '0;
  logic done, err;

  smvm_if #(.K(K), .VAL_W(VAL_W), .COL_W(COL_W), .ACC_W(ACC_W)) bus ();

  smvm_stream_engine #(.K(K), .VAL_W(VAL_W), .MAX_COLS(MAX_COLS), .ACC_W(ACC_W),
                       .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_cols(cfg_cols),
    .bus(bus), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_fail  = 0;
  bit sender_done;
  logic [ACC_W-1:0] got_q [$];
  logic [ACC_W-1:0] exp_q [$];
  logic [VAL_W-1:0] xv [MAX_COLS];

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic start_job(input int cols);
    got_q.delete();
    exp_q.delete();
    hs_fail = 0;
    cfg_cols = (COL_W + 1)'(cols);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_vec(input int n);
    for (int i = 0; i < n; i++) begin
      logic r;
      int t;
      r = 1'b0;
      t = 0;
      bus.vec_valid = 1'b1;
      bus.vec_data  = xv[i];
      while (!r && t < 200) begin
        @(negedge clk);
        r = bus.vec_ready;
        tick();
        t++;
      end
      bus.vec_valid = 1'b0;
      if (!r) hs_fail++;
    end
  endtask

  task automatic send_pkt(input logic [3:0] en, input logic [31:0] val, input logic [31:0] col,
                          input logic [3:0] rend, input logic last);
    logic r;
    int t;
    r = 1'b0;
    t = 0;
    bus.mat_valid = 1'b1;
    bus.mat_en    = en;
    bus.mat_val   = val;
    bus.mat_col   = col;
    bus.mat_rend  = rend;
    bus.mat_last  = last;
    while (!r && t < 500) begin
      @(negedge clk);
      r = bus.mat_ready;
      tick();
      t++;
    end
    bus.mat_valid = 1'b0;
    bus.mat_last  = 1'b0;
    if (!r) hs_fail++;
  endtask

  task automatic finish_job(input string tag, input logic exp_err);
    bit seen;
    int t;
    seen = 1'b0;
    t = 0;
    while (!seen && t < 3000) begin
      @(negedge clk);
      seen = done;
      t++;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_hs"}, 32'(hs_fail), 32'd0);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_nres"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_res%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic job_t1(input string tag);
    xv[0] = 8'd1; xv[1] = 8'd2; xv[2] = 8'd3; xv[3] = 8'd4;
    start_job(4);
    load_vec(4);
    check({tag, "_vec_ready_low"}, 32'(bus.vec_ready), 32'd0);
    check({tag, "_mat_ready_high"}, 32'(bus.mat_ready), 32'd1);
    send_pkt(4'b1111, pack4(1, 1, 1, 1), pack4(0, 1, 2, 3), 4'b1000, 1'b1);
    exp_q.push_back(24'd10);
    finish_job(tag, 1'b0);
  endtask

  initial begin
    bus.vec_valid = 1'b0; bus.vec_data = '0;
    bus.mat_valid = 1'b0; bus.mat_en = '0; bus.mat_val = '0; bus.mat_col = '0;
    bus.mat_rend = '0; bus.mat_last = 1'b0; bus.out_ready = 1'b1;
    repeat (3) tick();
    check("rst_vec_ready", 32'(bus.vec_ready), 32'd0);
    check("rst_mat_ready", 32'(bus.mat_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();

    job_t1("t1");

    // Row spanning three packets: 12 lanes of 2*5.
    xv[0] = 8'd5;
    start_job(1);
    load_vec(1);
    send_pkt(4'b1111, pack4(2, 2, 2, 2), 32'd0, 4'b0000, 1'b0);
    send_pkt(4'b1111, pack4(2, 2, 2, 2), 32'd0, 4'b0000, 1'b0);
    send_pkt(4'b1111, pack4(2, 2, 2, 2), 32'd0, 4'b1000, 1'b1);
    exp_q.push_back(24'd120);
    finish_job("t2", 1'b0);

    // Four one-lane rows per packet under output backpressure.
    xv[0] = 8'd3;
    start_job(1);
    load_vec(1);
    bus.out_ready = 1'b0;
    sender_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 5; p++) begin
          send_pkt(4'b1111, pack4(1, 2, 3, 4), 32'd0, 4'b1111, 1'(p == 4));
        end
        sender_done = 1'b1;
      end
    join_none
    repeat (20) tick();
    check("t3_mat_ready_full", 32'(bus.mat_ready), 32'd0);
    check("t3_out_valid_held", 32'(bus.out_valid), 32'd1);
    check("t3_no_pop", 32'(got_q.size()), 32'd0);
    bus.out_ready = 1'b1;
    for (int t = 0; t < 500 && !sender_done; t++) tick();
    for (int p = 0; p < 5; p++) begin
      exp_q.push_back(24'd3); exp_q.push_back(24'd6);
      exp_q.push_back(24'd9); exp_q.push_back(24'd12);
    end
    finish_job("t3", 1'b0);

    // Column 7 out of range; dangling tail 3*2 + 1*1 flushed at the end.
    xv[0] = 8'd1; xv[1] = 8'd2; xv[2] = 8'd3; xv[3] = 8'd4;
    start_job(4);
    load_vec(4);
    send_pkt(4'b1111, pack4(1, 1, 1, 1), pack4(0, 7, 2, 3), 4'b1000, 1'b0);
    send_pkt(4'b0011, pack4(3, 1, 0, 0), pack4(1, 0, 0, 0), 4'b0000, 1'b1);
    exp_q.push_back(24'd8);
    exp_q.push_back(24'd7);
    finish_job("t4", 1'b1);

    // Full-scale 256-element row.
    for (int i = 0; i < MAX_COLS; i++) xv[i] = 8'd255;
    start_job(256);
    load_vec(256);
    for (int p = 0; p < 64; p++) begin
      send_pkt(4'b1111, pack4(255, 255, 255, 255), pack4(4 * p, 4 * p + 1, 4 * p + 2, 4 * p + 3),
               (p == 63) ? 4'b1000 : 4'b0000, 1'(p == 63));
    end
    exp_q.push_back(24'd16646400);
    finish_job("t5", 1'b0);

    // Reset with two results queued, then a fresh job.
    xv[0] = 8'd2;
    start_job(1);
    load_vec(1);
    bus.out_ready = 1'b0;
    send_pkt(4'b0011, pack4(1, 1, 0, 0), 32'd0, 4'b0011, 1'b0);
    repeat (5) tick();
    check("t6_queued", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_mat_ready", 32'(bus.mat_ready), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    job_t1("t6_fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
